codec_i2c_sequencer: RTL
========================

# codec_i2c_sequencer

Hardware boot-time configurator for the audio codec. On a `start` pulse it walks a register table and issues one 16-bit-address / 16-bit-data I2C write per entry. It owns the open-drain I2C pins while busy and hands them to the SoC I2C master when idle. It sits between the SoC's `i2c_*` ports and the board SDA/SCL pads, so the codec is configured before software touches it.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `I2C_HZ`, 100_000: SCL rate. Quarter-period divider `DIV = CLK_HZ/(4*I2C_HZ)`, which must be ≥ 2.
- `DEV_ADDR`, 7'h0A: 7-bit codec device address.
- `NUM_WRITES`, 8: table entries, from 1 to 16.

Ports:
- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins the sequence; ignored while `busy`.
- `tbl_index` out 4: current table entry.
- `tbl_reg_addr` in 16: codec register address for `tbl_index`. Combinational ROM, valid the same cycle.
- `tbl_reg_data` in 16: data for `tbl_index`.
- `busy` out 1: sequence in progress; the sequencer owns the bus.
- `done` out 1: sticky; the sequence completed with all ACKs.
- `nack_err` out 1: sticky; a NACK aborted the sequence.
- `err_index` out 4: entry that NACKed.
- `soc_sda_oe`, `soc_scl_oe` in 1: SoC master pull-down requests.
- `i2c_sda_in`, `i2c_scl_in` in 1: pad readback, shared with the SoC.
- `i2c_sda_oe`, `i2c_scl_oe` out 1: registered. 1 pulls the line low; 0 releases it.

## Operation
- FSM states: IDLE, START, BYTE, ACK, STOP, GAP, FIN.
- Each state consumes quarter-ticks from a divider. The divider counter clears on entry to START.
- START (4 quarters):
  - q0: SDA and SCL released.
  - q1–q2: SDA pulled.
  - q3: SCL pulled.
- BYTE: 8 bits, MSB first, 4 quarters per bit.
  - q0–q1: SCL pulled; SDA oe = ~bit, set at q0.
  - q2–q3: SCL released.
- ACK (4 quarters): same SCL pattern as a bit, with SDA released. Sample `i2c_sda_in` on the tick ending q2. A 1 means NACK.
- Byte order per entry: {DEV_ADDR,0}, reg_addr[15:8], reg_addr[7:0], data[15:8], data[7:0].
- STOP (4 quarters):
  - q0: SCL and SDA pulled.
  - q1–q2: SCL released, SDA pulled.
  - q3: SDA released.
- After STOP, one of three things happens:
  - NACK seen: go to FIN with `nack_err`=1 and `err_index`=entry.
  - Otherwise, if the entry was the last: FIN with `done`=1.
  - Otherwise: GAP (4 quarters, bus released), increment `tbl_index`, then START.
- A NACK in any ACK slot goes directly to STOP. No further bytes are sent for that entry.
- FIN: `busy`=0, return to IDLE. `done`/`nack_err` remain until the next accepted `start`, which clears both on its first cycle.
- Clock stretching: in q2 of a bit or ACK, the divider freezes while `i2c_scl_in`=0.
- Bus mux, registered: when `busy`=0, `i2c_x_oe` <= `soc_x_oe`. When `busy`=1, SoC requests are ignored.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `nack_err`=0, `err_index`=0, `tbl_index`=0.
  - `i2c_sda_oe`=0, `i2c_scl_oe`=0; SoC passthrough resumes the cycle after `Reset` deasserts.
  - FSM in IDLE.
- `Reset` mid-transaction: both oe are 0 on the next edge. No STOP is generated.
- `start` handling:
  - `start` accepted in IDLE: `busy`=1 on the next edge; START q0 begins the same edge.
  - `start` during `busy`: no effect.
  - `start` coinciding with `Reset`: Reset wins.
- Lengths:
  - One entry is 188 quarters: START 4 + 5×36 + STOP 4.
  - GAP is 4 quarters.
  - A full unstretched sequence is `(188*NUM_WRITES + 4*(NUM_WRITES-1))*DIV` cycles from `busy` rising to `done` rising.
- SoC passthrough latency: 1 cycle.
- `tbl_index` is stable for an entire entry. The table is read only at byte loads.

## Test plan
1. DIV=2, NUM_WRITES=2, table {(0x0030,0x4060),(0x0010,0x3C3C)}, slave always ACKs, pulse `start`:
   - SDA bytes decode as 0x14,0x00,0x30,0x40,0x60, then 0x14,0x00,0x10,0x3C,0x3C.
   - `done`=1 exactly 760 cycles after `busy` rises.
   - `nack_err`=0.
2. Same setup, slave NACKs the third byte of entry 1:
   - STOP follows immediately; no entry-1 data bytes are sent.
   - `nack_err`=1, `err_index`=1, `done`=0, `busy`=0.
3. Slave holds `i2c_scl_in` low for 50 cycles during q2 of bit 3 of the first byte:
   - Sequence completes with correct data.
   - Total length is 760+50 (±1) cycles.
4. Idle passthrough and busy isolation:
   - Idle: toggle `soc_sda_oe`/`soc_scl_oe`; pads follow 1 cycle later.
   - During `busy`: SoC toggles have no effect on the pads.
5. Assert `Reset` for 1 cycle during entry 0 byte 2:
   - Next cycle: both oe=0, `busy`=0, `tbl_index`=0.
   - A fresh `start` reruns from entry 0.
6. Pulse `start` again while `busy`: ignored, timing unchanged. After a NACK abort, a new `start` clears `nack_err` on its first cycle.

Source files
------------

// File: rtl/codec_i2c_sequencer.sv
// Boot-time codec configurator: walks a register table and issues 16-bit-address /
// 16-bit-data I2C writes, owning the pads while busy and passing the SoC master through otherwise.
module codec_i2c_sequencer #(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         I2C_HZ     = 100_000,
  parameter logic [6:0] DEV_ADDR   = 7'h0A,
  parameter int         NUM_WRITES = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  output logic [3:0]  tbl_index,
  input  logic [15:0] tbl_reg_addr,
  input  logic [15:0] tbl_reg_data,
  output logic        busy,
  output logic        done,
  output logic        nack_err,
  output logic [3:0]  err_index,
  input  logic        soc_sda_oe,
  input  logic        soc_scl_oe,
  input  logic        i2c_sda_in,
  input  logic        i2c_scl_in,
  output logic        i2c_sda_oe,
  output logic        i2c_scl_oe
);

  localparam int              DIV        = CLK_HZ / (4 * I2C_HZ);
  localparam int              CW         = $clog2(DIV + 1);
  localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);
  localparam logic [3:0]      LAST_ENTRY = 4'(NUM_WRITES - 1);

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, GAP, FIN} state_t;

  state_t        state, state_n;
  logic [1:0]    quarter, quarter_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [2:0]    byte_cnt, byte_cnt_n;
  logic [CW-1:0] div_cnt, div_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          nacked, nacked_n;
  logic [3:0]    tbl_index_n, err_index_n;
  logic          busy_n, done_n, nack_err_n;
  logic          sda_oe_n, scl_oe_n;
  logic          freeze, tick;
  logic [2:0]    load_idx;
  logic [7:0]    load_byte;

  // A slave holding SCL low during the high phase stretches the clock.
  assign freeze = ((state == BYTE) || (state == ACK)) && (quarter == 2'd2) && !i2c_scl_in;
  assign tick   = (div_cnt == DIV_LAST) && !freeze;

  always_comb begin
    load_idx = (state == ACK) ? byte_cnt + 3'd1 : 3'd0;
    case (load_idx)
      3'd0:    load_byte = {DEV_ADDR, 1'b0};
      3'd1:    load_byte = tbl_reg_addr[15:8];
      3'd2:    load_byte = tbl_reg_addr[7:0];
      3'd3:    load_byte = tbl_reg_data[15:8];
      default: load_byte = tbl_reg_data[7:0];
    endcase
  end

  always_comb begin
    state_n     = state;
    quarter_n   = quarter;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    div_cnt_n   = div_cnt;
    shreg_n     = shreg;
    nacked_n    = nacked;
    tbl_index_n = tbl_index;
    err_index_n = err_index;
    busy_n      = busy;
    done_n      = done;
    nack_err_n  = nack_err;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = START;
          quarter_n   = 2'd0;
          div_cnt_n   = '0;
          byte_cnt_n  = 3'd0;
          tbl_index_n = 4'd0;
          nacked_n    = 1'b0;
          busy_n      = 1'b1;
          done_n      = 1'b0;
          nack_err_n  = 1'b0;
        end
      end
      FIN: state_n = IDLE;
      default: begin
        if (!freeze) div_cnt_n = tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          quarter_n = quarter + 2'd1;
          if ((state == ACK) && (quarter == 2'd2) && i2c_sda_in) nacked_n = 1'b1;
          if (quarter == 2'd3) begin
            case (state)
              START: begin
                state_n   = BYTE;
                bit_cnt_n = 3'd0;
                shreg_n   = load_byte;
              end
              BYTE: begin
                if (bit_cnt == 3'd7) begin
                  state_n = ACK;
                end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  shreg_n   = {shreg[6:0], 1'b0};
                end
              end
              ACK: begin
                if (nacked || (byte_cnt == 3'd4)) begin
                  state_n = STOP;
                end else begin
                  state_n    = BYTE;
                  byte_cnt_n = byte_cnt + 3'd1;
                  bit_cnt_n  = 3'd0;
                  shreg_n    = load_byte;
                end
              end
              STOP: begin
                if (nacked) begin
                  state_n     = FIN;
                  busy_n      = 1'b0;
                  nack_err_n  = 1'b1;
                  err_index_n = tbl_index;
                end else if (tbl_index == LAST_ENTRY) begin
                  state_n = FIN;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                end else begin
                  state_n = GAP;
                end
              end
              GAP: begin
                state_n     = START;
                tbl_index_n = tbl_index + 4'd1;
                byte_cnt_n  = 3'd0;
                nacked_n    = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Pad drive is derived from the position being entered so it lines up with the state register.
  always_comb begin
    sda_oe_n = 1'b0;
    scl_oe_n = 1'b0;
    case (state_n)
      START: begin
        sda_oe_n = (quarter_n != 2'd0);
        scl_oe_n = (quarter_n == 2'd3);
      end
      BYTE: begin
        sda_oe_n = ~shreg_n[7];
        scl_oe_n = ~quarter_n[1];
      end
      ACK:  scl_oe_n = ~quarter_n[1];
      STOP: begin
        sda_oe_n = (quarter_n != 2'd3);
        scl_oe_n = (quarter_n == 2'd0);
      end
      GAP: ;
      default: begin
        sda_oe_n = soc_sda_oe;
        scl_oe_n = soc_scl_oe;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      quarter    <= 2'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      div_cnt    <= '0;
      shreg      <= 8'd0;
      nacked     <= 1'b0;
      tbl_index  <= 4'd0;
      err_index  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack_err   <= 1'b0;
      i2c_sda_oe <= 1'b0;
      i2c_scl_oe <= 1'b0;
    end else begin
      state      <= state_n;
      quarter    <= quarter_n;
      bit_cnt    <= bit_cnt_n;
      byte_cnt   <= byte_cnt_n;
      div_cnt    <= div_cnt_n;
      shreg      <= shreg_n;
      nacked     <= nacked_n;
      tbl_index  <= tbl_index_n;
      err_index  <= err_index_n;
      busy       <= busy_n;
      done       <= done_n;
      nack_err   <= nack_err_n;
      i2c_sda_oe <= sda_oe_n;
      i2c_scl_oe <= scl_oe_n;
    end
  end

endmodule
